led_pattern_scheduler: RTL
==========================

// Module: led_pattern_scheduler
// PURPOSE
//  Shares the single board user_led between NREQ requesters (boot, link-up, error, ...).
//  Each requester asks for one fixed-length blink pattern; round-robin arbitration picks one.
//  The granted pattern plays bit by bit at a prescaled rate, then the LED is re-arbitrated.
//  When no pattern is playing, the LED shows the free-running heartbeat (bit HB_BIT of a counter).
//  Sits in the sys_clk domain, directly upstream of the user_led pad.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  PAT_LEN     8   bits per pattern (>=2)
//  PRESCALE_W  22  prescaler width; each pattern bit lasts 2**PRESCALE_W cycles
//  HB_W        26  heartbeat counter width; idle LED = hb_cnt[HB_W-1]
// PORTS
//  sys_clk   in   1             system clock (125 MHz board clock after IBUFDS)
//  sys_rst   in   1             synchronous, active-high reset
//  req       in   NREQ          level request, one bit per requester
//  pattern   in   NREQ*PAT_LEN  requester i pattern at [i*PAT_LEN +: PAT_LEN]; bit 0 plays first
//  grant     out  NREQ          one-hot owner of the LED; 0 when idle
//  done      out  NREQ          1-cycle pulse to the owner when its pattern finishes
//  busy      out  1             high while a pattern plays
//  user_led  out  1             LED drive
// BEHAVIOUR
//  - Clock sys_clk; reset sys_rst is synchronous and active-high.
//  - Reset: state=IDLE, grant=0, done=0, busy=0, hb_cnt=0 (user_led=0), prescaler=0,
//    bit_idx=0, rr_ptr=0 (requester 0 has top priority first).
//  - hb_cnt increments every cycle and wraps modulo 2**HB_W; it never stops, even during PLAY.
//  - FSM states IDLE, PLAY:
//    IDLE: if req!=0, pick the first set bit at or after rr_ptr (cyclic). Next cycle: PLAY,
//      grant one-hot, busy=1, pat_reg<=pattern slice, bit_idx=0, prescaler=0,
//      rr_ptr<=winner+1 mod NREQ. If req==0, stay in IDLE.
//    PLAY: prescaler increments every cycle; tick = (prescaler == all ones), and the
//      prescaler wraps to 0. On tick: if bit_idx<PAT_LEN-1, bit_idx++. If bit_idx==PAT_LEN-1,
//      next cycle: IDLE, grant=0, busy=0, done[winner]=1 for exactly that one cycle.
//  - Latency: grant is asserted 1 cycle after a req is sampled in IDLE. Play lasts exactly
//    PAT_LEN*2**PRESCALE_W cycles. The IDLE cycle that carries done also arbitrates, so the
//    minimum gap between back-to-back patterns is 1 cycle.
//  - user_led = busy ? pat_reg[bit_idx] : hb_cnt[HB_W-1]. It is a mux of registers only
//    (no combinational path from req or pattern).
//  - pattern is sampled only at grant; changes to pattern during PLAY are ignored.
//  - req deasserting during PLAY is ignored: the pattern completes and done still pulses.
//  - A requester holding req high is re-served only after all other pending requesters
//    (round-robin).
//  - Simultaneous done and new req in the same cycle: the new request is arbitrated in that cycle.
//  - sys_rst during PLAY aborts immediately: no done pulse, all outputs return to reset values.
//  - Arbitration is never in an unknown state: grant is either 0 or one-hot.
// STRUCTURE
//  - Package led_ctrl_pkg: state enum {IDLE, PLAY}; default constants PAT_LEN=8,
//    PRESCALE_W=22, HB_W=26.
//  - Sub-module rr_arbiter: parameter NREQ; inputs req and rr_ptr; outputs a combinational
//    one-hot winner and a valid flag. The parent owns and updates rr_ptr.
//  - Top level holds the FSM, prescaler, bit_idx, pat_reg, hb_cnt and the output mux.
// TESTING (bench uses PRESCALE_W=3, i.e. 8 cycles/bit; PAT_LEN=8; HB_W=6; NREQ=4)
//  1. Reset, then no req for 64 cycles -> busy=0, grant=0; user_led=0 for cycles 0-31 and
//     =1 for cycles 32-63.
//  2. req=0001, pattern[7:0]=8'b1010_0101 -> grant=0001 one cycle later; user_led follows
//     1,0,1,0,0,1,0,1 for 8 cycles each; done=0001 for 1 cycle 64 cycles after grant rises.
//  3. req=1111 held continuously -> grants in order 0001,0010,0100,1000,0001, with a
//     1-cycle IDLE gap between each.
//  4. Change pattern[7:0] and drop req[0] midway through playback -> the original
//     pattern completes unchanged and done[0] still pulses.
//  5. Assert sys_rst at bit 3 of a pattern -> next cycle grant=0, busy=0, done=0,
//     user_led=0, and no done pulse appears later.
//  6. After serving requester 2, assert req=0101 -> requester 0 wins, because rr_ptr=3
//     wraps around to 0.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and default sizes for the LED pattern scheduler.
// Latency: n/a (types only). Backpressure: n/a.
package led_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    localparam int DEF_PAT_LEN    = 8;
    localparam int DEF_PRESCALE_W = 22;
    localparam int DEF_HB_W       = 26;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first set request at or after rr_ptr_i, one-hot out.
// Latency: combinational. Backpressure: none, the parent decides when to consume.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [NREQ-1:0]  winner_o,
    output logic             valid_o
);

    int best_dist;
    int sel;

    // Cyclic distance from the pointer; the smallest distance among requesters wins.
    always_comb begin
        best_dist = NREQ;
        sel       = 0;
        valid_o   = |req_i;
        winner_o  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i] && (((i + NREQ - int'(rr_ptr_i)) % NREQ) < best_dist)) begin
                best_dist = (i + NREQ - int'(rr_ptr_i)) % NREQ;
                sel       = i;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            winner_o[i] = valid_o && (sel == i);
        end
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Shares user_led between NREQ requesters: round-robin grant, plays a blink pattern, else heartbeat.
// Latency: grant 1 cycle after req seen in IDLE; play PAT_LEN*2**PRESCALE_W cycles; done 1-cycle pulse.
// Backpressure: req is a level; later requesters wait in IDLE arbitration, req drops during play ignored.
module led_pattern_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int PAT_LEN    = DEF_PAT_LEN,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int HB_W       = DEF_HB_W
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*PAT_LEN-1:0]   pattern,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic                      user_led
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDX_W = $clog2(PAT_LEN);

    state_e                 state_q, state_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic [PAT_LEN-1:0]     pat_q, pat_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [PRESCALE_W-1:0]  pre_q, pre_d;
    logic [HB_W-1:0]        hb_q;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0]        arb_win;
    logic                   arb_vld;
    logic [PAT_LEN-1:0]     win_pat;
    logic [PTR_W-1:0]       win_nxt_ptr;
    logic                   tick;
    logic                   last_bit;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (arb_win),
        .valid_o  (arb_vld)
    );

    always_comb begin
        win_pat     = '0;
        win_nxt_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_win[i]) begin
                win_pat     = pattern[i*PAT_LEN +: PAT_LEN];
                win_nxt_ptr = PTR_W'((i + 1) % NREQ);
            end
        end
    end

    assign tick     = (pre_q == {PRESCALE_W{1'b1}});
    assign last_bit = (bit_idx_q == IDX_W'(PAT_LEN - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        pat_d     = pat_q;
        bit_idx_d = bit_idx_q;
        pre_d     = pre_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d   = PLAY;
                    grant_d   = arb_win;
                    pat_d     = win_pat;
                    bit_idx_d = '0;
                    pre_d     = '0;
                    rr_ptr_d  = win_nxt_ptr;
                end
            end
            PLAY: begin
                pre_d = pre_q + 1'b1;
                if (tick) begin
                    if (last_bit) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        done_d    = grant_q;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            pat_q     <= '0;
            bit_idx_q <= '0;
            pre_q     <= '0;
            hb_q      <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            pat_q     <= pat_d;
            bit_idx_q <= bit_idx_d;
            pre_q     <= pre_d;
            hb_q      <= hb_q + 1'b1;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Output is a pure mux of registers, so no path from req/pattern reaches the pad.
    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = (state_q == PLAY);
    assign user_led = busy ? pat_q[bit_idx_q] : hb_q[HB_W-1];

endmodule
